bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 140 ++++++++++++++
 tb/tb_bit_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial converter with a 2-entry input FIFO. Words are accepted
//   with a valid/ready handshake and shifted out one bit per cycle (MSB or LSB
//   first), back-to-back when the FIFO holds the next word.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   din        parallel word (WIDTH bits)
//   din_valid  din holds a valid word
//   din_ready  a word can be accepted this cycle (FIFO not full)
//   stall      freezes the shifter; outputs forced low while set
//   x          serial data bit (registered)
//   bit_vld    x carries a real data bit (registered)
//   word_done  pulse with the last bit of each word (registered)
//   busy       shifter active or FIFO non-empty
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int DEPTH     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             stall,
    output logic             x,
    output logic             bit_vld,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W   = $clog2(WIDTH);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);
    localparam logic [COUNT_W-1:0] FULL  = COUNT_W'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    // FIFO
    logic [WIDTH-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [COUNT_W-1:0] count;
    logic               push, pop;
    logic [WIDTH-1:0]   head;

    // Shifter
    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic               x_n, vld_n, done_n;

    assign din_ready = (count < FULL);
    assign push      = din_valid && din_ready;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state == SHIFT) || (count != '0);
    assign cnt_inc   = cnt + 1'b1;

    // Bit k of the word as it appears on the line.
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CNT_W-1:0] k);
        logic [CNT_W-1:0] idx;
        idx = MSB_FIRST ? (LAST - k) : k;
        return w[idx];
    endfunction

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // cnt is the index of the bit currently on x, so a pop registers bit 0
    // immediately; this gives first-bit latency of one edge after the pop.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        x_n     = 1'b0;
        vld_n   = 1'b0;
        done_n  = 1'b0;
        pop     = 1'b0;
        if (!stall) begin
            if (state == SHIFT && cnt != LAST) begin
                cnt_n  = cnt_inc;
                x_n    = pick(shreg, cnt_inc);
                vld_n  = 1'b1;
                done_n = (cnt_inc == LAST);
            end else if (count != '0) begin
                // IDLE, or end of word with another word waiting
                pop     = 1'b1;
                shreg_n = head;
                cnt_n   = '0;
                state_n = SHIFT;
                x_n     = pick(head, '0);
                vld_n   = 1'b1;
            end else if (state == SHIFT) begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            x         <= 1'b0;
            bit_vld   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            x         <= x_n;
            bit_vld   <= vld_n;
            word_done <= done_n;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   Directed bench for bit_serializer: one MSB-first and one LSB-first
//   instance (WIDTH=8) sharing clock, reset and stall.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst, stall;
    logic [7:0] din_a, din_b;
    logic       valid_a, valid_b;
    logic       ready_a, x_a, vld_a, done_a, busy_a;
    logic       ready_b, x_b, vld_b, done_b, busy_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
        .stall(stall), .x(x_a), .bit_vld(vld_a), .word_done(done_a), .busy(busy_a)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
        .stall(stall), .x(x_b), .bit_vld(vld_b), .word_done(done_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  exp8;
        logic [23:0] stream;
        logic [7:0]  words [3];
        int          wi, nbits, ndone, first_vld, last_vld;
        logic        accept, seen;

        rst = 1'b1; stall = 1'b0;
        din_a = '0; din_b = '0; valid_a = 1'b0; valid_b = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("rst_x",     x_a,     0);
        check_eq("rst_vld",   vld_a,   0);
        check_eq("rst_done",  done_a,  0);
        check_eq("rst_busy",  busy_a,  0);
        check_eq("rst_ready", ready_a, 1);
        check_eq("rst_vld_b", vld_b,   0);
        tick;
        tick;
        rst = 1'b1;
        tick;

        // Single word, MSB first
        exp8 = 8'b1011_0000;
        din_a = 8'hB0; valid_a = 1'b1;
        tick;
        valid_a = 1'b0;
        check_eq("single_lat_vld", vld_a, 0);
        check_eq("single_busy", busy_a, 1);
        for (int i = 0; i < 8; i++) begin
            tick;
            check_eq($sformatf("single_x%0d", i), x_a, exp8[7-i]);
            check_eq($sformatf("single_vld%0d", i), vld_a, 1);
            check_eq($sformatf("single_done%0d", i), done_a, (i == 7) ? 1 : 0);
        end
        tick;
        check_eq("single_end_vld", vld_a, 0);
        check_eq("single_end_busy", busy_a, 0);

        // LSB first: 8'h0D -> 1,0,1,1,0,0,0,0
        exp8 = 8'b1011_0000;
        din_b = 8'h0D; valid_b = 1'b1;
        tick;
        valid_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            check_eq($sformatf("lsb_x%0d", i), x_b, exp8[7-i]);
            check_eq($sformatf("lsb_vld%0d", i), vld_b, 1);
            check_eq($sformatf("lsb_done%0d", i), done_b, (i == 7) ? 1 : 0);
        end
        tick;

        // Back-to-back three words, din_valid held high
        words[0] = 8'hB0; words[1] = 8'h0B; words[2] = 8'hFF;
        stream = 24'hB00BFF;
        wi = 0; nbits = 0; ndone = 0; first_vld = -1; last_vld = -1;
        din_a = words[0]; valid_a = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            accept = valid_a && ready_a;
            tick;
            if (accept) begin
                wi++;
                if (wi < 3) din_a = words[wi];
                else valid_a = 1'b0;
            end
            if (cyc == 1) check_eq("b2b_ready_cnt1", ready_a, 1);
            if (cyc == 2) check_eq("b2b_ready_full", ready_a, 0);
            if (vld_a) begin
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
                if (nbits < 24) begin
                    check_eq($sformatf("b2b_x%0d", nbits), x_a, stream[23-nbits]);
                    check_eq($sformatf("b2b_done%0d", nbits), done_a, (nbits % 8 == 7) ? 1 : 0);
                end
                nbits++;
            end
            if (done_a) ndone++;
        end
        valid_a = 1'b0;
        check_eq("b2b_nbits", nbits, 24);
        check_eq("b2b_first", first_vld, 1);
        check_eq("b2b_contig", last_vld - first_vld + 1, 24);
        check_eq("b2b_ndone", ndone, 3);
        check_eq("b2b_accepted", wi, 3);

        // Stall for 3 cycles after bit 3 of 8'hA5
        exp8 = 8'hA5;
        din_a = 8'hA5; valid_a = 1'b1;
        tick;
        valid_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check_eq($sformatf("stall_pre_x%0d", i), x_a, exp8[7-i]);
            check_eq($sformatf("stall_pre_vld%0d", i), vld_a, 1);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_eq($sformatf("stall_vld%0d", i), vld_a, 0);
            check_eq($sformatf("stall_x%0d", i), x_a, 0);
            check_eq($sformatf("stall_done%0d", i), done_a, 0);
            check_eq($sformatf("stall_busy%0d", i), busy_a, 1);
        end
        stall = 1'b0;
        for (int i = 4; i < 8; i++) begin
            tick;
            check_eq($sformatf("stall_post_x%0d", i), x_a, exp8[7-i]);
            check_eq($sformatf("stall_post_vld%0d", i), vld_a, 1);
            check_eq($sformatf("stall_post_done%0d", i), done_a, (i == 7) ? 1 : 0);
        end
        tick;
        check_eq("stall_end_vld", vld_a, 0);

        // Reset during bit 2 with one word queued
        din_a = 8'hFF; valid_a = 1'b1;
        tick;
        din_a = 8'hC3;
        tick;
        valid_a = 1'b0;
        tick;
        tick;
        check_eq("rstmid_pre_x", x_a, 1);
        check_eq("rstmid_pre_vld", vld_a, 1);
        check_eq("rstmid_pre_busy", busy_a, 1);
        rst = 1'b0;
        #1;
        check_eq("rstmid_x", x_a, 0);
        check_eq("rstmid_vld", vld_a, 0);
        check_eq("rstmid_done", done_a, 0);
        check_eq("rstmid_ready", ready_a, 1);
        check_eq("rstmid_busy", busy_a, 0);
        tick;
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (vld_a || busy_a) seen = 1'b1;
        end
        check_eq("rstmid_no_resume", seen, 0);
        din_a = 8'h80; valid_a = 1'b1;
        tick;
        valid_a = 1'b0;
        tick;
        check_eq("rstmid_new_x", x_a, 1);
        check_eq("rstmid_new_vld", vld_a, 1);
        for (int i = 0; i < 9; i++) tick;
        check_eq("rstmid_new_idle", busy_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
